// File: rtl/rob_commit_if.sv
// Issue, CDB and commit signal bundle of the reorder buffer.
// The master side is the issue stage, functional units and writeback; the slave side is the ROB.
interface rob_commit_if #(
    parameter int IDX_W  = 3,
    parameter int REG_W  = 4,
    parameter int FUNC_W = 4,
    parameter int DATA_W = 16
);
    // allocation request from issue
    logic              alloc_valid;
    logic [FUNC_W-1:0] alloc_func;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_tag;

    // result broadcast
    logic              cdb_valid;
    logic [IDX_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    // in-order retirement to the register file
    logic              commit_valid;
    logic [REG_W-1:0]  commit_rd;
    logic [FUNC_W-1:0] commit_func;
    logic [DATA_W-1:0] commit_data;
    logic [IDX_W-1:0]  commit_tag;

    // occupancy
    logic [IDX_W:0]    count;
    logic              empty;

    modport master (
        output alloc_valid, alloc_func, alloc_rd,
        output cdb_valid, cdb_tag, cdb_data,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_rd, commit_func, commit_data, commit_tag,
        input  count, empty
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rd,
        input  cdb_valid, cdb_tag, cdb_data,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_rd, commit_func, commit_data, commit_tag,
        output count, empty
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: allocates at the tail, completes entries from the CDB by tag,
// and retires done entries strictly in order from the head, one per cycle.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int REG_W  = 4,
    parameter int FUNC_W = 4,
    parameter int DATA_W = 16
) (
    input  logic        clk1,
    input  logic        rst_n,
    rob_commit_if.slave bus
);
    localparam logic [IDX_W:0] LP_FULL = (IDX_W + 1)'(DEPTH);

    // per-entry state
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_done;
    logic [FUNC_W-1:0] r_func  [DEPTH];
    logic [REG_W-1:0]  r_rd    [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];

    // pointers and occupancy
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;

    // registered commit port
    logic              r_commit_valid;
    logic [REG_W-1:0]  r_commit_rd;
    logic [FUNC_W-1:0] r_commit_func;
    logic [DATA_W-1:0] r_commit_data;
    logic [IDX_W-1:0]  r_commit_tag;

    logic              w_alloc_ready;
    logic              w_alloc;
    logic              w_cdb_hit;
    logic              w_commit;

    // event decode, all from registered state plus the request strobes
    always_comb begin
        w_alloc_ready = (r_count != LP_FULL);
        w_alloc       = bus.alloc_valid && w_alloc_ready;
        w_cdb_hit     = bus.cdb_valid && r_busy[bus.cdb_tag];
        w_commit      = r_busy[r_head] && r_done[r_head];
    end

    // control state: busy/done bits, pointers and count.
    // The CDB can never hit the tail slot during an allocation (that slot is free
    // pre-edge, and when full no allocation happens), so the update order below
    // only matters for commit vs. allocate, which touch different slots unless empty.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_cdb_hit) begin
                r_done[bus.cdb_tag] <= 1'b1;
            end
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_head         <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_busy[r_tail] <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_tail         <= r_tail + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // entry payload; only meaningful while busy, so it needs no reset
    always_ff @(posedge clk1) begin
        if (w_cdb_hit) begin
            r_value[bus.cdb_tag] <= bus.cdb_data;
        end
        if (w_alloc) begin
            r_func[r_tail]  <= bus.alloc_func;
            r_rd[r_tail]    <= bus.alloc_rd;
            r_value[r_tail] <= '0;
        end
    end

    // commit port: one-cycle valid pulse, payload holds between commits
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_func  <= '0;
            r_commit_data  <= '0;
            r_commit_tag   <= '0;
        end else begin
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_commit_rd   <= r_rd[r_head];
                r_commit_func <= r_func[r_head];
                r_commit_data <= r_value[r_head];
                r_commit_tag  <= r_head;
            end
        end
    end

    assign bus.alloc_ready  = w_alloc_ready;
    assign bus.alloc_tag    = r_tail;
    assign bus.commit_valid = r_commit_valid;
    assign bus.commit_rd    = r_commit_rd;
    assign bus.commit_func  = r_commit_func;
    assign bus.commit_data  = r_commit_data;
    assign bus.commit_tag   = r_commit_tag;
    assign bus.count        = r_count;
    assign bus.empty        = (r_count == '0);

endmodule
